spi_master_param: RTL
=====================

Name: spi_master_param

Overview:
Parametrised full-duplex SPI master, the successor to the fixed 12-bit transmit-only SPI block. It takes one word per request over a ready/valid-style handshake, shifts it out on mosi while capturing miso, and returns the received word with a done pulse. Word width, sclk divider, SPI mode (CPOL/CPHA) and bit order are configurable. It sits between a system-clock controller (e.g. a DAC/ADC driver) and an off-chip SPI slave. All logic runs on clk; sclk is a registered output, never used as a clock.

Parameters:
DATA_WIDTH, 12, bits per transfer (2..32)
CLK_DIV, 50, clk cycles per sclk half-period (>=1)
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first; 0 = LSB first

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous assert, active-high
new_data  in  1  request a transfer; accepted only when ready=1
data_in  in  DATA_WIDTH  word to transmit; latched on the accepting edge
ready  out  1  high when IDLE and able to accept new_data
data_out  out  DATA_WIDTH  last received word; valid from the done cycle until the next done
done  out  1  one-cycle pulse at end of transfer
sclk  out  1  SPI clock
cs  out  1  chip select, active-low
mosi  out  1  serial data out
miso  in  1  serial data in; assumed already synchronous to clk

Behaviour:
- Reset values (asynchronous on rst=1): state=IDLE, sclk=CPOL, cs=1, mosi=0, done=0, data_out=0, all counters=0. Reset mid-transfer aborts immediately with no done pulse.
- ready = (state==IDLE), combinational.
- FSM states:
  - IDLE:
    - On new_data&&ready: latch data_in into the shift register, clear the bit counter, go to SETUP.
    - new_data while ready=0 is ignored and not queued.
  - SETUP:
    - cs=0 starting the cycle after acceptance; lasts CLK_DIV cycles with sclk held at CPOL.
    - For CPHA=0, mosi presents the first bit for the whole of SETUP.
  - XFER:
    - 2*DATA_WIDTH half-periods of CLK_DIV cycles each; sclk toggles at the end of each half-period.
    - CPHA=0: sample miso on leading (odd) edges; shift mosi to the next bit on trailing edges.
    - CPHA=1: update mosi on leading edges; sample miso on trailing edges.
    - After the last edge, sclk=CPOL; go to HOLD.
  - HOLD:
    - CLK_DIV cycles with cs=0 and mosi holding the last bit.
    - On exit: cs=1, mosi=0, data_out=receive register, done=1 for one cycle, go to IDLE.
- Bit order: MSB_FIRST selects the shift direction. Received bits are assembled so that data_out equals the transmitted word under loopback.
- Timing:
  - Latency from accept edge to done: (2*DATA_WIDTH+2)*CLK_DIV + 1 cycles.
  - cs is low for exactly (2*DATA_WIDTH+2)*CLK_DIV cycles.
- Back-to-back: ready=1 in the done cycle, so new_data may be accepted there. cs stays high for exactly 1 cycle before falling again.
- data_in changes after acceptance have no effect on the transfer in progress.
- Divider counter width: $clog2(CLK_DIV+1). It counts 0..CLK_DIV-1 and wraps; it is held at 0 in IDLE so the first half-period is always full length.

Decomposition:
- Package spi_pkg: state enum spi_state_t {IDLE, SETUP, XFER, HOLD}; localparam helper for counter widths.
- Sub-module spi_tick_gen (parameter CLK_DIV): ports clk, rst, en; emits a one-cycle tick every CLK_DIV cycles while en=1 and resets its count when en=0. The FSM advances only on ticks.

Test Plan:
- Mode 0, DATA_WIDTH=12, CLK_DIV=4, MSB_FIRST=1, miso looped to mosi, send 12'hA5C:
  - mosi sampled on sclk rising edges reads 1010_0101_1100.
  - cs is low for 104 cycles.
  - done fires once, 105 cycles after accept; data_out=12'hA5C.
- Mode 3 (CPOL=1, CPHA=1), LSB first, miso driven from the model word 12'h3C1, send 12'h0F0:
  - sclk idles high.
  - mosi sampled on rising edges reads the bits of 12'h0F0 LSB first.
  - data_out=12'h3C1.
- Back-to-back: assert new_data in the done cycle with 12'h123:
  - cs high for exactly 1 cycle, then the second transfer completes normally.
  - Two done pulses total.
- Busy ignore: pulse new_data with 12'hFFF mid-transfer:
  - No effect on mosi; no extra transfer; a single done.
- Reset mid-XFER (after 5 bits):
  - Outputs go to reset values within the same cycle (asynchronous); no done.
  - ready=1 after rst deasserts; next transfer of 12'h555 is correct.
- CLK_DIV=1, DATA_WIDTH=8, mode 0: sclk period is 2 clk cycles; loopback of 8'h81 returns 8'h81.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

    // Transfer sequencing: chip-select setup, bit shifting, chip-select hold.
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } spi_state_t;

    // Number of bits needed to hold values 0..maxCount.
    function automatic int cntWidth(input int maxCount);
        return $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timebase: one-cycle tick every CLK_DIV clk cycles while enabled.
module spi_tick_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = cntWidth(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count_q;

    // Count clk cycles within a half-period; held at zero while disabled so the
    // first half-period after enabling is always full length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (!en || (count_q == LAST_COUNT)) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tick = en && (count_q == LAST_COUNT);

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: one word per request, received word
// returned with a single-cycle done pulse. sclk is a registered data output.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int CLK_DIV    = 50,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_data,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  sclk,
    output logic                  cs,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int EDGE_W = cntWidth(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);
    localparam logic IDLE_SCLK = (CPOL != 0);
    localparam logic CPHA1     = (CPHA != 0);
    localparam logic MSB_FIRST_B = (MSB_FIRST != 0);

    spi_state_t            state_q;
    logic [DATA_WIDTH-1:0] txShift_q;
    logic [DATA_WIDTH-1:0] rxShift_q;
    logic [EDGE_W-1:0]     edgeCnt_q;
    logic                  sclk_q;
    logic                  cs_q;
    logic                  mosi_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] dataOut_q;

    logic [DATA_WIDTH-1:0] txShift_d;
    logic [DATA_WIDTH-1:0] rxShift_d;
    logic                  leadingEdge;
    logic                  lastEdge;
    logic                  sampleEdge;
    logic                  shiftEdge;
    logic                  firstBitIn;
    logic                  txFirstBit;
    logic                  txNextBit;
    logic                  tick;

    // The divider only runs while a transfer is in progress.
    spi_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (state_q != IDLE),
        .tick(tick)
    );

    // Shift-direction and edge-role decoding shared by the FSM.
    always_comb begin
        if (MSB_FIRST_B) begin
            txShift_d  = {txShift_q[DATA_WIDTH-2:0], 1'b0};
            rxShift_d  = {rxShift_q[DATA_WIDTH-2:0], miso};
            firstBitIn = data_in[DATA_WIDTH-1];
            txFirstBit = txShift_q[DATA_WIDTH-1];
            txNextBit  = txShift_q[DATA_WIDTH-2];
        end else begin
            txShift_d  = {1'b0, txShift_q[DATA_WIDTH-1:1]};
            rxShift_d  = {miso, rxShift_q[DATA_WIDTH-1:1]};
            firstBitIn = data_in[0];
            txFirstBit = txShift_q[0];
            txNextBit  = txShift_q[1];
        end
        // Edge counter is even before a leading edge and odd before a trailing edge.
        leadingEdge = ~edgeCnt_q[0];
        lastEdge    = (edgeCnt_q == LAST_EDGE);
        sampleEdge  = CPHA1 ? ~leadingEdge : leadingEdge;
        // With CPHA=0 the final trailing edge does not shift, so mosi keeps the last bit through HOLD.
        shiftEdge   = CPHA1 ? leadingEdge : (~leadingEdge && ~lastEdge);
    end

    // Transfer sequencer with registered SPI pins, done pulse and received word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            txShift_q <= '0;
            rxShift_q <= '0;
            edgeCnt_q <= '0;
            sclk_q    <= IDLE_SCLK;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
            dataOut_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (new_data && ready) begin
                        txShift_q <= data_in;
                        rxShift_q <= '0;
                        edgeCnt_q <= '0;
                        cs_q      <= 1'b0;
                        mosi_q    <= CPHA1 ? 1'b0 : firstBitIn;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (tick) begin
                        sclk_q    <= lastEdge ? IDLE_SCLK : ~sclk_q;
                        edgeCnt_q <= edgeCnt_q + 1'b1;
                        if (sampleEdge) begin
                            rxShift_q <= rxShift_d;
                        end
                        if (shiftEdge) begin
                            txShift_q <= txShift_d;
                            mosi_q    <= CPHA1 ? txFirstBit : txNextBit;
                        end
                        if (lastEdge) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_q      <= 1'b1;
                        mosi_q    <= 1'b0;
                        dataOut_q <= rxShift_q;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready    = (state_q == IDLE);
    assign data_out = dataOut_q;
    assign done     = done_q;
    assign sclk     = sclk_q;
    assign cs       = cs_q;
    assign mosi     = mosi_q;

endmodule
